// File: rtl/iir_pkg.sv
// Shared types and defaults for the iir_mac_sched first-order IIR datapath.
// One shared 24x16 multiplier produces every product.
package iir_pkg;

    localparam int DW_DEF    = 8;
    localparam int OW_DEF    = 16;
    localparam int CW        = 8;
    localparam int A_RST_DEF = -1;
    localparam int B_RST_DEF = 4;
    localparam int ACC_W     = 40;
    localparam int MUL_AW    = 24;
    localparam int MUL_BW    = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRE0,
        PRE1,
        MAC0,
        MAC1,
        MAC2,
        MAC3,
        OUT
    } state_t;

endpackage

// File: rtl/iir_mac_sched_if.sv
// Sample, result and coefficient-load signals of iir_mac_sched.
// The DUT attaches through the slave modport.
interface iir_mac_sched_if
    import iir_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) ();

    logic                 cfg_we;
    logic signed [CW-1:0] cfg_a;
    logic signed [CW-1:0] cfg_b;
    logic                 cfg_err;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 busy;

    modport master (
        output cfg_we, cfg_a, cfg_b, in_valid, in_data, out_ready,
        input  cfg_err, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  cfg_we, cfg_a, cfg_b, in_valid, in_data, out_ready,
        output cfg_err, in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/iir_mul.sv
// Shared signed 24x16 -> 40 combinational multiplier.
module iir_mul
    import iir_pkg::*;
(
    input  logic signed [MUL_AW-1:0] a,
    input  logic signed [MUL_BW-1:0] b,
    output logic signed [ACC_W-1:0]  p
);

    assign p = ACC_W'(a) * ACC_W'(b);

endmodule

// File: rtl/iir_mac_sched.sv
// First-order IIR y(n) = b*x(n) + ab*x(n-1) + a2b*x(n-2) + a*y(n-1), one product per
// clock on a single shared multiplier; ab and a2b are precomputed after each coefficient load.
module iir_mac_sched
    import iir_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int A_RST = A_RST_DEF,
    parameter int B_RST = B_RST_DEF
) (
    input logic            clk,
    input logic            rst,
    iir_mac_sched_if.slave bus
);

    localparam logic signed [CW-1:0]     A_INIT   = CW'(A_RST);
    localparam logic signed [CW-1:0]     B_INIT   = CW'(B_RST);
    localparam logic signed [MUL_BW-1:0] AB_INIT  = MUL_BW'(A_RST * B_RST);
    localparam logic signed [MUL_AW-1:0] A2B_INIT = MUL_AW'(A_RST * A_RST * B_RST);

    state_t state;
    state_t state_nxt;

    logic signed [CW-1:0]     a_q;
    logic signed [CW-1:0]     b_q;
    logic signed [MUL_BW-1:0] ab_q;
    logic signed [MUL_AW-1:0] a2b_q;
    logic signed [DW-1:0]     xn_q;
    logic signed [DW-1:0]     x1_q;
    logic signed [DW-1:0]     x2_q;
    logic signed [OW-1:0]     y1_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     cfg_err_q;

    logic                     in_ready;
    logic                     out_valid;
    logic                     busy;
    logic                     accept;
    logic signed [MUL_AW-1:0] mul_a;
    logic signed [MUL_BW-1:0] mul_b;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  acc_sum;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.cfg_we)  state_nxt = PRE0;
                else if (accept) state_nxt = MAC0;
            end
            PRE0:    state_nxt = PRE1;
            PRE1:    state_nxt = IDLE;
            MAC0:    state_nxt = MAC1;
            MAC1:    state_nxt = MAC2;
            MAC2:    state_nxt = MAC3;
            MAC3:    state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default first, so no state leaves a latch behind.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        mul_a     = '0;
        mul_b     = '0;
        unique case (state)
            IDLE: in_ready = !bus.cfg_we && !rst;
            PRE0: begin mul_a = MUL_AW'(a_q);  mul_b = MUL_BW'(b_q);  end
            PRE1: begin mul_a = MUL_AW'(a_q);  mul_b = ab_q;          end
            MAC0: begin mul_a = MUL_AW'(b_q);  mul_b = MUL_BW'(xn_q); end
            MAC1: begin mul_a = MUL_AW'(ab_q); mul_b = MUL_BW'(x1_q); end
            MAC2: begin mul_a = a2b_q;         mul_b = MUL_BW'(x2_q); end
            MAC3: begin mul_a = MUL_AW'(a_q);  mul_b = MUL_BW'(y1_q); end
            OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept  = bus.in_valid && in_ready;
    assign acc_sum = acc_q + prod;

    iir_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // NOTE: history and accumulator are reset too, so a sample aborted by rst leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= A_INIT;
            b_q       <= B_INIT;
            ab_q      <= AB_INIT;
            a2b_q     <= A2B_INIT;
            xn_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            acc_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (bus.cfg_we) begin
                        a_q  <= bus.cfg_a;
                        b_q  <= bus.cfg_b;
                        x1_q <= '0;
                        x2_q <= '0;
                        y1_q <= '0;
                    end else if (accept) begin
                        xn_q <= bus.in_data;
                    end
                end
                PRE0:       ab_q  <= prod[MUL_BW-1:0];
                PRE1:       a2b_q <= prod[MUL_AW-1:0];
                MAC0:       acc_q <= prod;
                MAC1, MAC2: acc_q <= acc_sum;
                MAC3: begin
                    // History shifts as the result becomes visible in OUT.
                    acc_q <= acc_sum;
                    y1_q  <= acc_sum[OW-1:0];
                    x1_q  <= xn_q;
                    x2_q  <= x1_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_data  = acc_q[OW-1:0];
    assign bus.cfg_err   = cfg_err_q;

endmodule
